// File: rtl/matrix_result_drain.sv
// Double-buffered drain stage: captures one result vector per handshake and streams its elements out in order.
// Optional saturated-element counter enabled by defining MATRIX_DRAIN_SATCNT_EN.
module matrix_result_drain #(
    parameter int unsigned DATA_SIZE   = 16,
    parameter int unsigned COLUMN_SIZE = 64,
    parameter int unsigned INDEX_W     = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_SIZE*COLUMN_SIZE-1:0]  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_SIZE-1:0]              out_data,
    output logic [INDEX_W-1:0]                out_index,
    output logic                              out_last,
    output logic                              busy,
    output logic [INDEX_W:0]                  sat_count
);

    localparam int unsigned VEC_W = DATA_SIZE * COLUMN_SIZE;
    localparam int unsigned CNT_W = INDEX_W + 1;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(COLUMN_SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [VEC_W-1:0]     active_q, active_d;
    logic [VEC_W-1:0]     pending_q, pending_d;
    logic                 pending_full_q, pending_full_d;
    logic                 out_valid_q, out_valid_d;
    logic [INDEX_W-1:0]   out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;

    logic in_hs;
    logic out_hs;
    logic final_hs;

    assign in_ready = ~pending_full_q;
    assign in_hs    = in_valid & ~pending_full_q;
    assign out_hs   = out_valid_q & out_ready;
    assign final_hs = out_hs & out_last_q;

    // Active buffer is a shift register: element 0 always sits in the low slice.
    assign out_data  = active_q[DATA_SIZE-1:0];
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        out_valid_d    = out_valid_q;
        out_index_d    = out_index_q;
        out_last_d     = out_last_q;

        if (clear) begin
            state_d        = IDLE;
            pending_full_d = 1'b0;
            out_valid_d    = 1'b0;
            out_index_d    = '0;
            out_last_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        active_d    = in_data;
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                    end
                end
                DRAIN: begin
                    if (final_hs) begin
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                        if (pending_full_q) begin
                            active_d       = pending_q;
                            pending_full_d = 1'b0;
                        end else if (in_hs) begin
                            active_d = in_data;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        if (out_hs) begin
                            active_d    = {{DATA_SIZE{1'b0}}, active_q[VEC_W-1:DATA_SIZE]};
                            out_index_d = out_index_q + INDEX_W'(1);
                            out_last_d  = (out_index_q + INDEX_W'(1)) == LAST_IDX;
                        end
                        if (in_hs) begin
                            pending_d      = in_data;
                            pending_full_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == DRAIN) | pending_full_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_index_q    <= '0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            out_valid_q    <= out_valid_d;
            out_index_q    <= out_index_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
        end
    end

`ifdef MATRIX_DRAIN_SATCNT_EN
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;
    logic             sat_hit;

    // All-ones elements are the upstream saturation marker.
    assign sat_hit = out_hs & (active_q[DATA_SIZE-1:0] == {DATA_SIZE{1'b1}});

    always_comb begin
        sat_cnt_d   = sat_cnt_q;
        sat_count_d = sat_count_q;
        if (clear) begin
            sat_cnt_d = '0;
        end else if (final_hs) begin
            sat_count_d = sat_cnt_q + CNT_W'(sat_hit);
            sat_cnt_d   = '0;
        end else if (sat_hit) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_cnt_q   <= '0;
            sat_count_q <= '0;
        end else begin
            sat_cnt_q   <= sat_cnt_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_matrix_result_drain.sv
// Scoreboard bench for matrix_result_drain: stimulus queues expected elements, a negedge monitor checks them.
module tb_matrix_result_drain;

    localparam int unsigned DW  = 16;
    localparam int unsigned CS  = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned VW  = DW * CS;

    logic            clock = 1'b0;
    logic            reset;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [VW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            busy;
    logic [IW:0]     sat_count;

    matrix_result_drain #(
        .DATA_SIZE  (DW),
        .COLUMN_SIZE(CS),
        .INDEX_W    (IW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy),
        .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_vec(input logic [VW-1:0] v, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d = v[k*DW +: DW];
            e.i = IW'(k);
            e.l = (k == CS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: a handshake will occur at the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_element", 64'(out_data), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data",  64'(out_data),  64'(e.d));
                check("out_index", 64'(out_index), 64'(e.i));
                check("out_last",  64'(out_last),  64'(e.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [VW-1:0] VA = 64'h0004_0003_0002_0001;
    localparam logic [VW-1:0] V0 = 64'h1D1C_1B1A_100B_100A;
    localparam logic [VW-1:0] V1 = 64'h2D2C_2B2A_200B_200A;
    localparam logic [VW-1:0] V2 = 64'h3D3C_3B3A_300B_300A;
    localparam logic [VW-1:0] VS = 64'hFFFF_0005_FFFF_FFFF;
    localparam logic [VW-1:0] VO = 64'h0001_0001_0001_0001;

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data",  64'(out_data),  0);
        check("rst_out_index", 64'(out_index), 0);
        check("rst_out_last",  64'(out_last),  0);
        check("rst_busy",      64'(busy),      0);
        check("rst_sat_count", 64'(sat_count), 0);
        check("rst_in_ready",  64'(in_ready),  1);
        tick();
        reset = 1'b0;
        tick();

        // Basic drain, one capture, latency 1, no gaps.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = VA; push_vec(VA, 4);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("basic_valid", 64'(out_valid), 1);
            tick();
        end
        check("basic_done_valid", 64'(out_valid), 0);
        check("basic_done_busy",  64'(busy),      0);

        // Backpressure with pending buffer full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = V0; push_vec(V0, 4);
        tick();
        in_data = V1; push_vec(V1, 4);
        check("bp_ready_before_v1", 64'(in_ready), 1);
        tick();
        in_data = V2;
        for (int j = 0; j < 3; j++) begin
            check("bp_in_ready_low", 64'(in_ready), 0);
            check("bp_busy",         64'(busy),     1);
            check("bp_data_stable",  64'(out_data), 64'h100A);
            check("bp_index_stable", 64'(out_index), 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("bp_stream_valid", 64'(out_valid), 1);
            check("bp_in_ready",     64'(in_ready),  (j >= 4) ? 1 : 0);
            tick();
        end
        check("bp_done_valid", 64'(out_valid), 0);

        // Zero-bubble bypass on the final handshake.
        in_valid = 1'b1; in_data = V0; push_vec(V0, 4);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) begin
                in_valid = 1'b1; in_data = V1; push_vec(V1, 4);
            end
            tick();
        end
        in_valid = 1'b0;
        check("bypass_valid", 64'(out_valid), 1);
        check("bypass_index", 64'(out_index), 0);
        for (int j = 0; j < 4; j++) tick();
        check("bypass_done_valid", 64'(out_valid), 0);

        // Clear mid-drain with pending full.
        in_valid = 1'b1; in_data = V0; push_vec(V0, 2);
        tick();
        in_data = V1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("pre_clear_index",    64'(out_index), 2);
        check("pre_clear_in_ready", 64'(in_ready),  0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_valid",    64'(out_valid), 0);
        check("clear_busy",     64'(busy),      0);
        check("clear_in_ready", 64'(in_ready),  1);
        check("clear_index",    64'(out_index), 0);
        check("clear_last",     64'(out_last),  0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = V2; push_vec(V2, 4);
        tick();
        in_valid = 1'b0;
        check("post_clear_index", 64'(out_index), 0);
        for (int j = 0; j < 4; j++) tick();
        check("post_clear_done", 64'(out_valid), 0);

        // Asynchronous reset mid-drain.
        in_valid = 1'b1; in_data = V0; push_vec(V0, 1);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check("arst_valid", 64'(out_valid), 0);
        check("arst_data",  64'(out_data),  0);
        check("arst_index", 64'(out_index), 0);
        check("arst_busy",  64'(busy),      0);
        tick();
        reset = 1'b0;
        tick();
        in_valid = 1'b1; in_data = V1; push_vec(V1, 4);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("post_rst_valid", 64'(out_valid), 1);
            tick();
        end
        check("post_rst_done", 64'(out_valid), 0);

        // Saturation counting.
        in_valid = 1'b1; in_data = VS; push_vec(VS, 4);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
`ifdef MATRIX_DRAIN_SATCNT_EN
        check("sat_count_three", 64'(sat_count), 3);
`else
        check("sat_count_off", 64'(sat_count), 0);
`endif
        in_valid = 1'b1; in_data = VO; push_vec(VO, 4);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        check("sat_count_zero", 64'(sat_count), 0);

        tick();
        check("scoreboard_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
